// File: rtl/audio_pwm_dac.sv
// audio_pwm_dac
//   Sample-to-PWM output stage for the aud_pwm pin. Unsigned samples come in
//   on a valid/ready stream and wait in a small FIFO. Each sample plays for
//   one PWM period of 2^SAMPLE_W clk cycles. The output is high for the
//   first <sample> cycles of that period.
//
// Ports
//   clk       system clock (clk_nes domain)
//   rst_n     asynchronous active-low reset
//   en        playback enable; 0 mutes the output and holds the counter at 0
//   s_data    unsigned sample; 0 is the silence floor
//   s_valid   sample valid
//   s_ready   FIFO has space (combinational from the registered level)
//   pwm       registered PWM output
//   underrun  one-cycle pulse: a period boundary was reached with the FIFO empty
//   level     current FIFO occupancy
module audio_pwm_dac #(
    parameter int SAMPLE_W   = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic [SAMPLE_W-1:0]         s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    output logic                        pwm,
    output logic                        underrun,
    output logic [$clog2(FIFO_DEPTH):0] level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0]    FULL    = LVL_W'(FIFO_DEPTH);
    localparam logic [SAMPLE_W-1:0] CNT_MAX = '1;

    logic [SAMPLE_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [SAMPLE_W-1:0] cnt;
    logic [SAMPLE_W-1:0] duty;

    logic push;
    logic pop;
    logic boundary;

    assign s_ready  = (level != FULL);
    assign push     = s_valid && s_ready;
    assign boundary = en && (cnt == CNT_MAX);
    assign pop      = boundary && (level != '0);
    // On an empty boundary the last duty repeats, so we only flag it.
    assign underrun = boundary && (level == '0);

    // Sample storage carries no reset. Occupancy is tracked by level, so
    // stale entries are never read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            cnt    <= '0;
            duty   <= '0;
            pwm    <= 1'b0;
        end else begin
            // Pointers wrap naturally because FIFO_DEPTH is a power of 2.
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase

            // The counter restarts at 0 whenever playback is muted. This
            // means re-enabling always begins a full period.
            cnt <= en ? cnt + SAMPLE_W'(1) : '0;

            // The new sample takes effect on the cycle where cnt returns to 0.
            if (pop) duty <= mem[rd_ptr];

            // Because cnt never reaches 2^SAMPLE_W, full-on output is
            // unreachable. This is intentional.
            pwm <= en && (cnt < duty);
        end
    end

endmodule

// File: tb/tb_audio_pwm_dac.sv
module tb_audio_pwm_dac;

    localparam int PER = 256;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic       pwm;
    logic       underrun;
    logic [3:0] level;

    int errors = 0;
    int checks = 0;

    // reference model: queued samples plus the duty currently playing
    int model_q[$];
    int model_duty;
    int exp_hi[$];
    int exp_und[$];

    // observations from play()
    int hi_cnt[$];
    int und_idx[$];
    int noncontig;

    audio_pwm_dac #(.SAMPLE_W(8), .FIFO_DEPTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .pwm      (pwm),
        .underrun (underrun),
        .level    (level)
    );

    always #5 clk = ~clk;

    // Each period plays the current sample. At its end the next queued
    // sample is taken, or an underrun is flagged on the last sampled cycle
    // before the boundary edge.
    task automatic predict(input int nper);
        exp_hi.delete();
        exp_und.delete();
        for (int k = 0; k < nper; k++) begin
            exp_hi.push_back(model_duty);
            if (model_q.size() > 0) model_duty = model_q.pop_front();
            else exp_und.push_back(k*PER + PER - 2);
        end
    endtask

    // Must be called at a negedge with cnt at 0. Enables playback and records
    // the per-period high counts, any non-contiguous highs, and the underrun
    // sample indices.
    task automatic play(input int nper);
        int  h;
        logic seen_low;
        hi_cnt.delete();
        und_idx.delete();
        noncontig = 0;
        en = 1'b1;
        for (int k = 0; k < nper; k++) begin
            h = 0;
            seen_low = 1'b0;
            for (int j = 0; j < PER; j++) begin
                @(negedge clk);
                if (pwm === 1'b1) begin
                    h++;
                    if (seen_low) noncontig++;
                end else seen_low = 1'b1;
                if (underrun === 1'b1) und_idx.push_back(k*PER + j);
            end
            hi_cnt.push_back(h);
        end
    endtask

    task automatic push(input logic [7:0] v);
        int t = 0;
        s_data  = v;
        s_valid = 1'b1;
        while (s_ready !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        s_valid = 1'b0;
        checks++;
        if (t >= 300) begin
            errors++;
            $display("FAIL push_timeout: s_ready=%b never rose, required 1", s_ready);
        end
        model_q.push_back(int'(v));
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        en      = 1'($urandom);
        s_valid = 1'($urandom);
        s_data  = 8'($urandom);
        #3;
        checks++; if (pwm !== 1'b0)      begin errors++; $display("FAIL rst_pwm: got %b want 0", pwm); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL rst_underrun: got %b want 0", underrun); end
        checks++; if (level !== 4'd0)    begin errors++; $display("FAIL rst_level: got %0d want 0", level); end
        repeat (3) @(negedge clk);
        en = 1'b0; s_valid = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", s_ready); end
        model_q.delete();
        model_duty = 0;
        predict(2);
        play(2);
        foreach (exp_hi[k]) begin
            checks++;
            if (hi_cnt[k] !== exp_hi[k]) begin errors++; $display("FAIL rst_hi[%0d]: got %0d want %0d", k, hi_cnt[k], exp_hi[k]); end
        end
        checks++;
        if (und_idx.size() !== exp_und.size()) begin errors++; $display("FAIL rst_und_count: got %0d want %0d", und_idx.size(), exp_und.size()); end
        else foreach (exp_und[k]) begin
            checks++;
            if (und_idx[k] !== exp_und[k]) begin errors++; $display("FAIL rst_und_at[%0d]: got %0d want %0d", k, und_idx[k], exp_und[k]); end
        end
    endtask

    task automatic test_single();
        en = 1'b0;
        @(negedge clk);
        push(8'h40);
        checks++; if (level !== 4'd1) begin errors++; $display("FAIL single_level: got %0d want 1", level); end
        predict(4);
        play(4);
        foreach (exp_hi[k]) begin
            checks++;
            if (hi_cnt[k] !== exp_hi[k]) begin errors++; $display("FAIL single_hi[%0d]: got %0d want %0d", k, hi_cnt[k], exp_hi[k]); end
        end
        checks++; if (noncontig !== 0) begin errors++; $display("FAIL single_contig: got %0d want 0", noncontig); end
        checks++;
        if (und_idx.size() !== exp_und.size()) begin errors++; $display("FAIL single_und_count: got %0d want %0d", und_idx.size(), exp_und.size()); end
        else foreach (exp_und[k]) begin
            checks++;
            if (und_idx[k] !== exp_und[k]) begin errors++; $display("FAIL single_und_at[%0d]: got %0d want %0d", k, und_idx[k], exp_und[k]); end
        end
    endtask

    task automatic test_sequence();
        en = 1'b0;
        @(negedge clk);
        push(8'h00);
        push(8'hFF);
        push(8'h80);
        predict(4);
        play(4);
        foreach (exp_hi[k]) begin
            checks++;
            if (hi_cnt[k] !== exp_hi[k]) begin errors++; $display("FAIL seq_hi[%0d]: got %0d want %0d", k, hi_cnt[k], exp_hi[k]); end
        end
        checks++; if (noncontig !== 0) begin errors++; $display("FAIL seq_contig: got %0d want 0", noncontig); end
        checks++; if (und_idx.size() !== exp_und.size()) begin errors++; $display("FAIL seq_und_count: got %0d want %0d", und_idx.size(), exp_und.size()); end
    endtask

    task automatic test_full();
        logic [7:0] ninth;
        en = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 8; i++) push(8'($urandom));
        ninth   = 8'($urandom);
        s_data  = ninth;
        s_valid = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (level !== 4'd8)    begin errors++; $display("FAIL full_level: got %0d want 8", level); end
        checks++; if (s_ready !== 1'b0)  begin errors++; $display("FAIL full_ready: got %b want 0", s_ready); end
        en = 1'b1;
        for (int i = 0; i < PER + 1; i++) begin
            @(negedge clk);
            if (i == PER - 2) begin
                checks++; if (level !== 4'd8) begin errors++; $display("FAIL full_pre_level: got %0d want 8", level); end
            end
            if (i == PER - 1) begin
                checks++; if (level !== 4'd7)   begin errors++; $display("FAIL full_pop_level: got %0d want 7", level); end
                checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL full_pop_ready: got %b want 1", s_ready); end
            end
            if (i == PER) begin
                checks++; if (level !== 4'd8)   begin errors++; $display("FAIL full_refill_level: got %0d want 8", level); end
                checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL full_refill_ready: got %b want 0", s_ready); end
            end
        end
        s_valid = 1'b0;
        en = 1'b0;
        model_duty = model_q.pop_front();
        model_q.push_back(int'(ninth));
        @(negedge clk);
        predict(9);
        play(9);
        foreach (exp_hi[k]) begin
            checks++;
            if (hi_cnt[k] !== exp_hi[k]) begin errors++; $display("FAIL full_hi[%0d]: got %0d want %0d", k, hi_cnt[k], exp_hi[k]); end
        end
        checks++; if (noncontig !== 0) begin errors++; $display("FAIL full_contig: got %0d want 0", noncontig); end
    endtask

    task automatic test_mute();
        int hi;
        int und;
        int lv_bad;
        en = 1'b0;
        @(negedge clk);
        push(8'h80);
        for (int i = 0; i < 3; i++) push(8'($urandom_range(1, 255)));
        predict(1);
        play(1);
        checks++; if (hi_cnt[0] !== exp_hi[0]) begin errors++; $display("FAIL mute_pre_hi: got %0d want %0d", hi_cnt[0], exp_hi[0]); end
        hi = 0;
        repeat (50) begin
            @(negedge clk);
            if (pwm === 1'b1) hi++;
        end
        checks++; if (hi !== 50) begin errors++; $display("FAIL mute_run_hi: got %0d want 50", hi); end
        en = 1'b0;
        @(negedge clk);
        checks++; if (pwm !== 1'b0)   begin errors++; $display("FAIL mute_pwm_off: got %b want 0", pwm); end
        checks++; if (level !== 4'd3) begin errors++; $display("FAIL mute_level: got %0d want 3", level); end
        hi = 0; und = 0; lv_bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (pwm === 1'b1) hi++;
            if (underrun === 1'b1) und++;
            if (level !== 4'd3) lv_bad++;
        end
        checks++; if (hi !== 0)     begin errors++; $display("FAIL mute_hold_pwm: got %0d highs want 0", hi); end
        checks++; if (und !== 0)    begin errors++; $display("FAIL mute_hold_und: got %0d pulses want 0", und); end
        checks++; if (lv_bad !== 0) begin errors++; $display("FAIL mute_hold_level: got %0d bad cycles want 0", lv_bad); end
        predict(3);
        play(3);
        foreach (exp_hi[k]) begin
            checks++;
            if (hi_cnt[k] !== exp_hi[k]) begin errors++; $display("FAIL mute_hi[%0d]: got %0d want %0d", k, hi_cnt[k], exp_hi[k]); end
        end
        checks++; if (noncontig !== 0) begin errors++; $display("FAIL mute_contig: got %0d want 0", noncontig); end
    endtask

    task automatic test_random();
        int n;
        for (int r = 0; r < 3; r++) begin
            en = 1'b0;
            @(negedge clk);
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) push(8'($urandom));
            checks++; if (level !== 4'(n)) begin errors++; $display("FAIL rand_level[%0d]: got %0d want %0d", r, level, n); end
            predict(n + 1);
            play(n + 1);
            foreach (exp_hi[k]) begin
                checks++;
                if (hi_cnt[k] !== exp_hi[k]) begin errors++; $display("FAIL rand_hi[%0d][%0d]: got %0d want %0d", r, k, hi_cnt[k], exp_hi[k]); end
            end
            checks++; if (noncontig !== 0) begin errors++; $display("FAIL rand_contig[%0d]: got %0d want 0", r, noncontig); end
            checks++;
            if (und_idx.size() !== exp_und.size()) begin errors++; $display("FAIL rand_und_count[%0d]: got %0d want %0d", r, und_idx.size(), exp_und.size()); end
            else foreach (exp_und[k]) begin
                checks++;
                if (und_idx[k] !== exp_und[k]) begin errors++; $display("FAIL rand_und_at[%0d]: got %0d want %0d", r, und_idx[k], exp_und[k]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        en = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) push(8'($urandom_range(200, 255)));
        en = 1'b1;
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        en = 1'b0;
        #1;
        checks++; if (pwm !== 1'b0)     begin errors++; $display("FAIL rmid_pwm: got %b want 0", pwm); end
        checks++; if (level !== 4'd0)   begin errors++; $display("FAIL rmid_level: got %0d want 0", level); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL rmid_underrun: got %b want 0", underrun); end
        rst_n = 1'b1;
        model_q.delete();
        model_duty = 0;
        @(negedge clk);
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b want 1", s_ready); end
        predict(2);
        play(2);
        foreach (exp_hi[k]) begin
            checks++;
            if (hi_cnt[k] !== exp_hi[k]) begin errors++; $display("FAIL rmid_hi[%0d]: got %0d want %0d", k, hi_cnt[k], exp_hi[k]); end
        end
        checks++;
        if (und_idx.size() !== exp_und.size()) begin errors++; $display("FAIL rmid_und_count: got %0d want %0d", und_idx.size(), exp_und.size()); end
        else foreach (exp_und[k]) begin
            checks++;
            if (und_idx[k] !== exp_und[k]) begin errors++; $display("FAIL rmid_und_at[%0d]: got %0d want %0d", k, und_idx[k], exp_und[k]); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_sequence();
        test_full();
        test_mute();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/audio_pwm_dac.md
Name: audio_pwm_dac

Overview:
Sample-to-PWM output stage that sits directly downstream of the tone/APU sample source. It drives the board's aud_pwm pin, with aud_sd gated separately at top level. It accepts unsigned samples on a valid/ready stream and buffers them in a small FIFO. It plays one sample per PWM period as a single-bit duty-cycle output in the clk_nes domain.

Parameters:
SAMPLE_W, 8, sample width in bits; the PWM period is 2^SAMPLE_W clk cycles.
FIFO_DEPTH, 8, sample FIFO entries; must be a power of 2 and at least 2.

Ports:
clk  in  1  system clock (clk_nes domain)
rst_n  in  1  asynchronous active-low reset
en  in  1  playback enable; 0 = mute and hold
s_data  in  SAMPLE_W  unsigned sample; 0 = silence floor
s_valid  in  1  sample valid
s_ready  out  1  FIFO has space
pwm  out  1  registered PWM output to aud_pwm
underrun  out  1  one-cycle pulse: period boundary reached with the FIFO empty
level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset is asynchronous and active-low, on one clock (clk).
- Reset values (immediate on rst_n=0): pwm=0, underrun=0, level=0, period counter cnt=0, duty register=0, FIFO read and write pointers=0. s_ready=1 once out of reset.
- Stream handshake:
  - s_ready = (level != FIFO_DEPTH), combinational from registered level.
  - A write occurs when s_valid && s_ready.
  - s_data is captured on the accepting edge.
  - Upstream may hold s_valid high across cycles.
- Period counter:
  - cnt is SAMPLE_W bits and increments every cycle while en=1.
  - It wraps from 2^SAMPLE_W-1 to 0.
  - While en=0, cnt is held at 0.
- Boundary = en && cnt == 2^SAMPLE_W-1.
  - At a boundary with level>0: duty <= FIFO head, pop.
  - At a boundary with level==0: duty is retained (last sample repeats) and underrun=1 for that cycle.
- Output:
  - pwm <= en && (cnt < duty), a registered compare with 1-cycle latency.
  - duty=0 gives pwm always 0.
  - duty=D gives exactly D high cycles, contiguous, at the start of each period.
  - Maximum duty is 2^SAMPLE_W-1 of 2^SAMPLE_W cycles; full-on is not reachable, by design.
- Timing: a pop at the boundary cycle t loads duty at t+1 (cnt=0). The first high pwm cycle of the new sample is t+2.
- Simultaneous push and pop in the same cycle: level is unchanged, both pointers advance, and the data is preserved.
- Full FIFO: s_ready=0, so no write occurs. A pop that cycle lowers level, and s_ready rises the next cycle. Writes are never dropped or overwritten.
- Empty FIFO and a push in the same cycle as a boundary: no pop (level was 0), underrun pulses, and the new sample waits for the next boundary.
- en falling mid-period:
  - pwm is 0 from the next edge and cnt returns to 0.
  - FIFO and duty are kept; no pops and no underrun pulses occur while muted.
  - Pushes are still accepted while space remains.
- en rising: a full period starts at cnt=0 with the retained duty.
- Pointers use FIFO_DEPTH-modulo wrap. level is the authoritative full/empty indicator.
- Reset mid-period: all state clears asynchronously, and buffered samples are discarded.

Test Plan:
1. Assert rst_n=0 with random inputs, then release. Required: pwm=0, underrun=0, level=0, s_ready=1. Required: no pwm activity for 256 cycles with en=1 and no samples, plus an underrun pulse every 256 cycles.
2. SAMPLE_W=8, en=1, push 0x40, then observe 3 periods. Required: after the first boundary, pwm is high exactly 64 consecutive cycles per 256. Required: underrun pulses at later boundaries while the duty stays 0x40.
3. Push 0x00, then 0xFF, then 0x80 back-to-back. Required: the per-period high counts are 0, 255 and 128 respectively, in order.
4. With en=0, push 9 samples while holding s_valid. Required: 8 accepted, level=8, s_ready=0 while the 9th waits. Then set en=1. Required: on the first boundary a pop occurs, level=7, s_ready=1. Required: the 9th sample is accepted the next cycle and level returns to 8.
5. Toggle en low mid-period while duty=0x80 with 3 samples queued. Required: pwm=0 within 1 cycle, level stays 3, no underrun. Re-enable. Required: the pwm period restarts from cnt=0 with 128 high cycles.
6. Pulse rst_n low for 1 ns mid-period with the FIFO half full. Required: pwm=0 and level=0 asynchronously. Required: after release, behaviour is identical to scenario 1.
